// File: rtl/memdev.sv
// Single-port Wishbone pipelined memory with configurable response latency.
// Requests are latched on acceptance and committed on the edge that enters RESP.
module memdev #(
    parameter int ADDRESS_WIDTH = 30,
    parameter int LGMEMSZ       = 10,
    parameter int WAIT_STATES   = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_we,
    input  logic [ADDRESS_WIDTH-1:0] i_wb_addr,
    input  logic [31:0]              i_wb_data,
    input  logic [3:0]               i_wb_sel,
    output logic                     o_wb_stall,
    output logic                     o_wb_ack,
    output logic                     o_wb_err,
    output logic [31:0]              o_wb_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int MEM_WORDS = 1 << LGMEMSZ;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t state;
    state_t state_nxt;
    logic [3:0] wait_cnt;
    logic resp_err_p1;

    logic                     req_we_p1;
    logic [ADDRESS_WIDTH-1:0] req_addr_p1;
    logic [31:0]              req_data_p1;
    logic [3:0]               req_sel_p1;

    logic [31:0] mem [MEM_WORDS];

    logic                     accept;
    logic                     commit;
    logic                     cmt_we;
    logic [ADDRESS_WIDTH-1:0] cmt_addr;
    logic [31:0]              cmt_data;
    logic [3:0]               cmt_sel;
    logic                     cmt_oor;
    logic [LGMEMSZ-1:0]       cmt_idx;

    function automatic logic out_of_range(input logic [ADDRESS_WIDTH-1:0] a);
        return (a >> LGMEMSZ) != '0;
    endfunction

    assign accept = (state == S_IDLE) && i_wb_cyc && i_wb_stb;
    // Reset held across an edge must never let a request reach memory.
    assign commit = !i_rst && (state != S_RESP) && (state_nxt == S_RESP);

    // With zero wait states the commit happens on the accepting edge, so the
    // live bus inputs stand in for the not-yet-latched request.
    assign cmt_we   = (state == S_IDLE) ? i_wb_we   : req_we_p1;
    assign cmt_addr = (state == S_IDLE) ? i_wb_addr : req_addr_p1;
    assign cmt_data = (state == S_IDLE) ? i_wb_data : req_data_p1;
    assign cmt_sel  = (state == S_IDLE) ? i_wb_sel  : req_sel_p1;
    assign cmt_oor  = out_of_range(cmt_addr);
    assign cmt_idx  = cmt_addr[LGMEMSZ-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_wb_cyc) begin
                    state_nxt = S_IDLE;
                end else if (wait_cnt == 4'd0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_wb_stall = (state != S_IDLE);
        o_wb_ack   = (state == S_RESP) && !resp_err_p1;
        o_wb_err   = (state == S_RESP) && resp_err_p1;
    end

    // Request capture stage
    always_ff @(posedge i_clk) begin
        if (accept) begin
            req_we_p1   <= i_wb_we;
            req_addr_p1 <= i_wb_addr;
            req_data_p1 <= i_wb_data;
            req_sel_p1  <= i_wb_sel;
        end
    end

    // Commit stage: wait counter, response kind and read data
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_cnt    <= 4'd0;
            resp_err_p1 <= 1'b0;
            o_wb_data   <= 32'd0;
        end else begin
            if (accept) begin
                wait_cnt <= WAIT_INIT;
            end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit) begin
                resp_err_p1 <= cmt_oor;
                if (cmt_oor) begin
                    o_wb_data <= 32'd0;
                end else if (!cmt_we) begin
                    o_wb_data <= mem[cmt_idx];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (commit && cmt_we && !cmt_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (cmt_sel[i]) begin
                    mem[cmt_idx][8*i +: 8] <= cmt_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_memdev.sv
// Scoreboarded random/directed bench for memdev at zero and three wait states.
`timescale 1ns/1ps
module tb_memdev;
    localparam int AW = 30;
    localparam int LG = 10;

    typedef struct {
        int          due;
        bit          err;
        bit          upd;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit done [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int WS = (g == 0) ? 0 : 3;

        logic          rst, cyc, stb, we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    sel;
        logic          stall, ack, err;
        logic [31:0]   rdata;

        int          cnt = 0;
        int          b_lo = 0;
        int          b_hi = -2;
        bit [31:0]   mdl [1 << LG];
        logic [31:0] exp_rdata = 32'd0;
        ent_t        sb [$];

        memdev #(
            .ADDRESS_WIDTH(AW),
            .LGMEMSZ(LG),
            .WAIT_STATES(WS)
        ) u_dut (
            .i_clk(clk),
            .i_rst(rst),
            .i_wb_cyc(cyc),
            .i_wb_stb(stb),
            .i_wb_we(we),
            .i_wb_addr(addr),
            .i_wb_data(wdata),
            .i_wb_sel(sel),
            .o_wb_stall(stall),
            .o_wb_ack(ack),
            .o_wb_err(err),
            .o_wb_data(rdata)
        );

        always @(posedge clk) cnt <= cnt + 1;

        // Monitor: cnt is the number of rising edges seen so far.
        always @(negedge clk) begin
            bit   due_now;
            ent_t e;
            #1;
            if (rst) begin
                exp_rdata = 32'd0;
                chk($sformatf("ws%0d_rst_stall", WS), 32'(stall), 32'd0);
                chk($sformatf("ws%0d_rst_ack", WS), 32'(ack), 32'd0);
                chk($sformatf("ws%0d_rst_err", WS), 32'(err), 32'd0);
                chk($sformatf("ws%0d_rst_data", WS), rdata, 32'd0);
            end else begin
                chk($sformatf("ws%0d_stall@%0d", WS, cnt), 32'(stall), 32'(cnt >= b_lo && cnt <= b_hi));
                chk($sformatf("ws%0d_ack_err_excl", WS), 32'(ack & err), 32'd0);
                due_now = (sb.size() > 0) && (sb[0].due == cnt);
                chk($sformatf("ws%0d_resp_present@%0d", WS, cnt), 32'(ack | err), 32'(due_now));
                if (due_now) begin
                    e = sb.pop_front();
                    if (ack | err) chk($sformatf("ws%0d_resp_is_err@%0d", WS, cnt), 32'(err), 32'(e.err));
                    if (e.upd) exp_rdata = e.data;
                end
                chk($sformatf("ws%0d_rdata@%0d", WS, cnt), rdata, exp_rdata);
            end
        end

        // kind 0: normal transfer, 1: drop cyc while waiting, 2: reset while waiting.
        task automatic issue(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int gap, input int kind);
            int            acc;
            int            target;
            ent_t          e;
            logic [LG-1:0] idx;
            idx = a[LG-1:0];
            if (gap == 0) begin
                acc = b_hi + 2;
            end else begin
                while (cnt < b_hi) @(negedge clk);
                if (gap >= 2) begin
                    cyc = 1'b0;
                    stb = 1'($urandom);
                end
                target = b_hi + ((gap < 2) ? 1 : gap - 1);
                while (cnt < target) @(negedge clk);
                acc = cnt + 1;
            end
            cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
            while (cnt < acc) @(negedge clk);
            stb = 1'b0; we = 1'($urandom); addr = AW'($urandom); wdata = $urandom; sel = 4'($urandom);
            b_lo = acc;
            b_hi = acc + WS;
            if (kind == 0) begin
                e.due  = acc + WS;
                e.err  = (a >> LG) != '0;
                e.upd  = 1'b1;
                e.data = 32'd0;
                if (!e.err) begin
                    if (w) begin
                        for (int b = 0; b < 4; b++)
                            if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
                        e.upd = 1'b0;
                    end else begin
                        e.data = mdl[idx];
                    end
                end
                sb.push_back(e);
            end else if (kind == 1) begin
                @(negedge clk);
                cyc  = 1'b0;
                b_hi = acc + 1;
            end else begin
                b_hi = acc - 1;
                rst  = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                cyc = 1'b0;
            end
        endtask

        initial begin
            logic [AW-1:0] ra;
            rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
            addr = '0; wdata = 32'd0; sel = 4'd0;
            #1 rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);

            for (int i = 0; i < 16; i++)
                issue(1'b1, AW'(i), $urandom, 4'hF, int'($urandom_range(0, 2)), 0);

            issue(1'b1, AW'(5), 32'h12345678, 4'hF, 2, 0);
            issue(1'b0, AW'(5), $urandom, 4'h0, 0, 0);
            issue(1'b1, AW'(7), 32'hAABBCCDD, 4'hF, 3, 0);
            issue(1'b1, AW'(7), 32'h11223344, 4'b0101, 0, 0);
            issue(1'b0, AW'(7), $urandom, 4'h0, 1, 0);
            issue(1'b0, AW'(7), $urandom, 4'hF, 0, 0);

            issue(1'b0, AW'('h400), $urandom, 4'hF, 2, 0);
            issue(1'b1, AW'('h400), $urandom, 4'hF, 0, 0);
            issue(1'b0, AW'(0), $urandom, 4'hF, 1, 0);

            issue(1'b1, AW'(3), $urandom, 4'h0, 2, 0);
            issue(1'b0, AW'(3), $urandom, 4'h0, 0, 0);

            if (WS >= 2) begin
                issue(1'b1, AW'(2), 32'h0BADF00D, 4'hF, 2, 0);
                issue(1'b1, AW'(2), 32'hDEADBEEF, 4'hF, 2, 1);
                issue(1'b0, AW'(2), $urandom, 4'hF, 2, 0);
                issue(1'b1, AW'(9), 32'hCAFEF00D, 4'hF, 2, 2);
                issue(1'b0, AW'(9), $urandom, 4'hF, 2, 0);
                issue(1'b0, AW'(2), $urandom, 4'hF, 0, 0);
            end

            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(0, 7) == 0)
                    ra = (AW'($urandom_range(1, 1000)) << LG) | AW'($urandom_range(0, 15));
                else
                    ra = AW'($urandom_range(0, 15));
                issue(1'($urandom), ra, $urandom, 4'($urandom), int'($urandom_range(0, 3)), 0);
            end

            while (cnt < b_hi + 2) @(negedge clk);
            cyc = 1'b0;
            stb = 1'b0;
            repeat (4) @(negedge clk);
            chk($sformatf("ws%0d_sb_drained", WS), 32'(sb.size()), 32'd0);
            done[g] = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 20000 && !(done[0] && done[1]); c++) @(posedge clk);
        chk("stimulus_done", 32'({done[0], done[1]}), 32'd3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
